display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 151 +++++++++++++++
 tb/tb_display_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin arbiter sharing one 4-digit display among three requesters (optional macro DISP_PRIORITY_EN)
module display_arbiter #(
    parameter int DWELL_CYCLES = 100000000,
    parameter int CNT_W        = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic [15:0] disp_value,
    output logic        disp_valid,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [1:0]       last_owner;
    logic [1:0]       winner_q;
    logic [CNT_W-1:0] counter;

    logic [1:0]       rr_winner;
    logic [1:0]       sel_winner;
    logic             dwell_end;
    logic             preempt;
    logic             take_grant;
    logic [2:0]       grant_d;
    logic             disp_valid_d;
    logic [15:0]      load_data;

    // Round-robin search starting one past the last shown requester
    always_comb begin
        rr_winner = 2'd0;
        case (last_owner)
            2'd0: begin
                if (req[1])      rr_winner = 2'd1;
                else if (req[2]) rr_winner = 2'd2;
                else             rr_winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      rr_winner = 2'd2;
                else if (req[0]) rr_winner = 2'd0;
                else             rr_winner = 2'd1;
            end
            default: begin
                if (req[0])      rr_winner = 2'd0;
                else if (req[1]) rr_winner = 2'd1;
                else             rr_winner = 2'd2;
            end
        endcase
    end

`ifdef DISP_PRIORITY_EN
    // Requester 0 overrides round-robin and may cut short a dwell owned by 1 or 2
    always_comb begin
        sel_winner = req[0] ? 2'd0 : rr_winner;
        preempt    = (state == SHOW) && req[0] && (owner != 2'd0);
    end
`else
    // Pure round-robin, never preempts a dwell
    always_comb begin
        sel_winner = rr_winner;
        preempt    = 1'b0;
    end
`endif

    // Dwell ends on the last counted SHOW cycle
    always_comb begin
        dwell_end = (state == SHOW) && (counter == DWELL_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req != 3'b000) next_state = LOAD;
            end
            LOAD: begin
                next_state = SHOW;
            end
            SHOW: begin
                if (preempt)                next_state = LOAD;
                else if (dwell_end)         next_state = (req != 3'b000) ? LOAD : IDLE;
                else                        next_state = SHOW;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: next grant and valid, plus the data captured while granted
    always_comb begin
        take_grant   = (next_state == LOAD) && (state != LOAD);
        grant_d      = take_grant ? (3'b001 << sel_winner) : 3'b000;
        disp_valid_d = (next_state == SHOW);
        case (winner_q)
            2'd0:    load_data = data0;
            2'd1:    load_data = data1;
            default: load_data = data2;
        endcase
    end

    // Registered outputs, winner latch and dwell counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= 3'b000;
            disp_value <= 16'h0000;
            disp_valid <= 1'b0;
            owner      <= 2'd2;
            last_owner <= 2'd2;
            winner_q   <= 2'd0;
            counter    <= '0;
        end else begin
            grant      <= grant_d;
            disp_valid <= disp_valid_d;
            if (take_grant) begin
                winner_q <= sel_winner;
            end
            if (state == LOAD) begin
                disp_value <= load_data;
                owner      <= winner_q;
                last_owner <= winner_q;
                counter    <= '0;
            end else if (state == SHOW && counter != DWELL_LAST) begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter with a 4-cycle dwell
module tb_display_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  grant;
    logic [15:0] disp_value;
    logic        disp_valid;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    display_arbiter #(
        .DWELL_CYCLES(DWELL),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data0(data0),
        .data1(data1),
        .data2(data2),
        .grant(grant),
        .disp_value(disp_value),
        .disp_valid(disp_valid),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 3'b000;
        data0 = 16'h0000;
        data1 = 16'h0000;
        data2 = 16'h0000;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 3'b000); end
        checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL reset_value got=%h exp=%h", disp_value, 16'h0000); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=%b", disp_valid, 1'b0); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL reset_owner got=%0d exp=%0d", owner, 2); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        test_reset();
        req   = 3'b010;
        data1 = 16'h1234;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant got=%b exp=%b", grant, 3'b010); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL single_load_valid got=%b exp=0", disp_valid); end
        req = 3'b000;
        for (int i = 0; i < DWELL; i++) begin
            tick();
            checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got=%b exp=1", i, disp_valid); end
            checks++; if (disp_value !== 16'h1234) begin errors++; $display("FAIL single_value[%0d] got=%h exp=1234", i, disp_value); end
            checks++; if (owner !== 2'd1) begin errors++; $display("FAIL single_owner[%0d] got=%0d exp=1", i, owner); end
            checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_show_grant[%0d] got=%b exp=000", i, grant); end
        end
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got=%b exp=0", disp_valid); end
        checks++; if (disp_value !== 16'h1234) begin errors++; $display("FAIL single_idle_hold got=%h exp=1234", disp_value); end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_idle_grant got=%b exp=000", grant); end
    endtask

    task automatic test_round_robin();
        int          idx;
        logic [2:0]  exp_g;
        logic [15:0] exp_v;
        test_reset();
        data0 = 16'hAAAA;
        data1 = 16'hBBBB;
        data2 = 16'hCCCC;
        req   = 3'b111;
        for (int g = 0; g < 4; g++) begin
            idx   = g % 3;
            exp_g = (idx == 0) ? 3'b001 : (idx == 1) ? 3'b010 : 3'b100;
            exp_v = (idx == 0) ? 16'hAAAA : (idx == 1) ? 16'hBBBB : 16'hCCCC;
            tick();
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", g, grant, exp_g); end
            checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rr_load_valid[%0d] got=%b exp=0", g, disp_valid); end
            for (int i = 0; i < DWELL; i++) begin
                tick();
                checks++; if (disp_value !== exp_v) begin errors++; $display("FAIL rr_value[%0d.%0d] got=%h exp=%h", g, i, disp_value, exp_v); end
                checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d.%0d] got=%b exp=1", g, i, disp_valid); end
                checks++; if (owner !== 2'(idx)) begin errors++; $display("FAIL rr_owner[%0d.%0d] got=%0d exp=%0d", g, i, owner, idx); end
            end
        end
        req = 3'b000;
        tick();
        checks++; if (disp_valid !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL rr_idle got=%b/%b exp=0/000", disp_valid, grant); end
    endtask

    task automatic test_snapshot();
        test_reset();
        req   = 3'b100;
        data2 = 16'h0001;
        tick();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL snap_grant got=%b exp=100", grant); end
        req = 3'b000;
        tick();
        data2 = 16'hFFFF;
        checks++; if (disp_value !== 16'h0001) begin errors++; $display("FAIL snap_first got=%h exp=0001", disp_value); end
        for (int i = 1; i < DWELL; i++) begin
            tick();
            checks++; if (disp_value !== 16'h0001) begin errors++; $display("FAIL snap_hold[%0d] got=%h exp=0001", i, disp_value); end
            checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL snap_valid[%0d] got=%b exp=1", i, disp_valid); end
        end
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL snap_end_valid got=%b exp=0", disp_valid); end
    endtask

    task automatic test_sole_requester();
        test_reset();
        req   = 3'b010;
        data1 = 16'h5A5A;
        for (int g = 0; g < 2; g++) begin
            tick();
            checks++; if (grant !== 3'b010) begin errors++; $display("FAIL sole_grant[%0d] got=%b exp=010", g, grant); end
            for (int i = 0; i < DWELL; i++) begin
                tick();
                checks++; if (disp_value !== 16'h5A5A || owner !== 2'd1) begin errors++; $display("FAIL sole_show[%0d.%0d] got=%h/%0d exp=5a5a/1", g, i, disp_value, owner); end
            end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_show();
        test_reset();
        req   = 3'b010;
        data1 = 16'h1234;
        tick();
        req = 3'b000;
        tick();
        tick();
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", disp_valid); end
        reset = 1'b1;
        #2;
        checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL mid_async_value got=%h exp=0000", disp_value); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", disp_valid); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_async_grant got=%b exp=000", grant); end
        reset = 1'b0;
        data0 = 16'hAAAA;
        data1 = 16'hBBBB;
        req   = 3'b011;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_regrant got=%b exp=001", grant); end
        req = 3'b010;
        tick();
        checks++; if (disp_value !== 16'hAAAA || owner !== 2'd0) begin errors++; $display("FAIL mid_reshow got=%h/%0d exp=aaaa/0", disp_value, owner); end
        req = 3'b000;
    endtask

    task automatic test_priority();
        test_reset();
        data0 = 16'hAAAA;
        data1 = 16'hBBBB;
        req   = 3'b010;
        tick();
        req = 3'b000;
        tick();
        checks++; if (disp_value !== 16'hBBBB || owner !== 2'd1) begin errors++; $display("FAIL prio_owner1 got=%h/%0d exp=bbbb/1", disp_value, owner); end
        req = 3'b001;
`ifdef DISP_PRIORITY_EN
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL prio_preempt_grant got=%b exp=001", grant); end
`else
        for (int i = 1; i < DWELL; i++) begin
            tick();
            checks++; if (disp_value !== 16'hBBBB || grant !== 3'b000) begin errors++; $display("FAIL prio_no_preempt[%0d] got=%h/%b exp=bbbb/000", i, disp_value, grant); end
        end
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL prio_late_grant got=%b exp=001", grant); end
`endif
        req = 3'b000;
        tick();
        checks++; if (disp_value !== 16'hAAAA || owner !== 2'd0) begin errors++; $display("FAIL prio_show0 got=%h/%0d exp=aaaa/0", disp_value, owner); end
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        data0 = 16'h0000;
        data1 = 16'h0000;
        data2 = 16'h0000;
        test_reset();
        test_single();
        test_round_robin();
        test_snapshot();
        test_sole_requester();
        test_reset_mid_show();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
